branch_predictor: RTL and testbench

- Dynamic branch predictor and redirect controller for the 5-stage RV32 pipeline.
- In IF: looks up fetch PC in a direct-mapped BTB/BHT and supplies the predicted next PC.
- In EX: takes the resolved outcome from the branch-condition logic (BEQ/BLT/BLTU), trains the table, and flags mispredicts so the hazard unit flushes IF/ID and redirects the PC.
- Keeps branch and mispredict counters for the debug bus.

---
 rtl/branch_predictor_pkg.sv | 43 ++++
 rtl/sat_counter2.sv | 19 +
 rtl/branch_predictor.sv | 80 ++++++++
 tb/tb_branch_predictor.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the BTB/BHT branch predictor.
// Holds the counter encodings, the table entry layout and the PC index/tag split.
package branch_predictor_pkg;

    localparam int unsigned ENTRIES = 16;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned TAG_W   = XLEN - IDX_W - 2;

    localparam logic [6:0] B_TYPE = 7'b1100011;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
        ctr_t             cnt;
    } btb_entry_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
    } pc_fields_t;

    // Caller passes pc[XLEN-1:2]; the byte offset never takes part in lookup.
    function automatic pc_fields_t pc_split(input logic [XLEN-3:0] pc_word);
        return pc_pkg_cast(pc_word);
    endfunction

    function automatic pc_fields_t pc_pkg_cast(input logic [XLEN-3:0] pc_word);
        pc_fields_t f;
        f.idx = pc_word[IDX_W-1:0];
        f.tag = pc_word[XLEN-3:IDX_W];
        return f;
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// Two-bit saturating counter next-state function.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       taken,
    output logic [1:0] cnt_next
);

    always_comb begin
        cnt_next = cnt;
        if (taken) begin
            if (cnt != ST) cnt_next = cnt + 2'd1;
        end else begin
            if (cnt != SNT) cnt_next = cnt - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB/BHT: zero-latency IF lookup, EX-stage training and
// mispredict/redirect generation, plus branch and mispredict counters.
module branch_predictor
    import branch_predictor_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_if,
    output logic            pred_taken_if,
    output logic [XLEN-1:0] pred_target_if,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     br_cnt,
    output logic [31:0]     miss_cnt
);

    btb_entry_t btb_q [ENTRIES];

    pc_fields_t f_if;
    pc_fields_t f_ex;
    btb_entry_t e_if;
    logic       hit_if;
    logic       hit_ex;
    logic       res;
    logic [1:0] cnt_upd;

    // IF lookup sees only the registered table, so same-cycle training is not bypassed.
    always_comb begin
        f_if           = pc_split(pc_if[XLEN-1:2]);
        e_if           = btb_q[f_if.idx];
        hit_if         = e_if.valid && (e_if.tag == f_if.tag);
        pred_taken_if  = hit_if && e_if.cnt[1];
        pred_target_if = pred_taken_if ? e_if.target : pc_if + XLEN'(4);
    end

    always_comb begin
        f_ex        = pc_split(ex_pc[XLEN-1:2]);
        hit_ex      = btb_q[f_ex.idx].valid && (btb_q[f_ex.idx].tag == f_ex.tag);
        res         = ex_valid && ex_is_branch;
        mispredict  = res && ((ex_taken != ex_pred_taken) ||
                              (ex_taken && (ex_pred_target != ex_target)));
        redirect_pc = ex_taken ? ex_target : ex_pc + XLEN'(4);
    end

    sat_counter2 u_sat (
        .cnt      (btb_q[f_ex.idx].cnt),
        .taken    (ex_taken),
        .cnt_next (cnt_upd)
    );

    // Training and statistics; a not-taken miss leaves the table alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: WNT};
            end
            br_cnt   <= '0;
            miss_cnt <= '0;
        end else begin
            if (res) begin
                br_cnt <= br_cnt + 32'd1;
                if (hit_ex) begin
                    btb_q[f_ex.idx].cnt <= ctr_t'(cnt_upd);
                    if (ex_taken) btb_q[f_ex.idx].target <= ex_target;
                end else if (ex_taken) begin
                    btb_q[f_ex.idx] <= '{valid: 1'b1, tag: f_ex.tag, target: ex_target, cnt: WT};
                end
            end
            if (mispredict) miss_cnt <= miss_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios with literal
// expectations, then randomized traffic against a behavioural table model.
module tb_branch_predictor;
    import branch_predictor_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] pc_if;
    logic        pred_taken_if;
    logic [31:0] pred_target_if;
    logic        ex_valid;
    logic        ex_is_branch;
    logic        ex_taken;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] br_cnt;
    logic [31:0] miss_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    bit done     = 0;

    branch_predictor dut (
        .clk            (clk),
        .rst            (rst),
        .pc_if          (pc_if),
        .pred_taken_if  (pred_taken_if),
        .pred_target_if (pred_target_if),
        .ex_valid       (ex_valid),
        .ex_is_branch   (ex_is_branch),
        .ex_taken       (ex_taken),
        .ex_pc          (ex_pc),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc),
        .br_cnt         (br_cnt),
        .miss_cnt       (miss_cnt)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Behavioural table: plain arrays, counter kept as an integer 0..3.
    bit          m_valid  [16];
    logic [31:0] m_tag    [16];
    logic [31:0] m_target [16];
    int          m_cnt    [16];
    logic [31:0] m_br;
    logic [31:0] m_miss;

    function automatic int midx(input logic [31:0] pc);
        return int'((pc >> 2) & 32'hF);
    endfunction

    function automatic bit mhit(input logic [31:0] pc);
        return m_valid[midx(pc)] && (m_tag[midx(pc)] == (pc >> 6));
    endfunction

    function automatic bit mpred(input logic [31:0] pc);
        return mhit(pc) && (m_cnt[midx(pc)] >= 2);
    endfunction

    function automatic logic [31:0] mtarget(input logic [31:0] pc);
        return mpred(pc) ? m_target[midx(pc)] : pc + 32'd4;
    endfunction

    function automatic bit mmis();
        bit wrong_dir;
        bit wrong_tgt;
        wrong_dir = (ex_taken != ex_pred_taken);
        wrong_tgt = ex_taken && (ex_pred_target != ex_target);
        return ex_valid && ex_is_branch && (wrong_dir || wrong_tgt);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                m_valid[i]  = 0;
                m_tag[i]    = 0;
                m_target[i] = 0;
                m_cnt[i]    = 1;
            end
            m_br   = 0;
            m_miss = 0;
        end else begin
            if (mmis()) m_miss = m_miss + 1;
            if (ex_valid && ex_is_branch) begin
                int i;
                i = midx(ex_pc);
                m_br = m_br + 1;
                if (mhit(ex_pc)) begin
                    if (ex_taken) begin
                        m_cnt[i]    = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
                        m_target[i] = ex_target;
                    end else begin
                        m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
                    end
                end else if (ex_taken) begin
                    m_valid[i]  = 1;
                    m_tag[i]    = ex_pc >> 6;
                    m_target[i] = ex_target;
                    m_cnt[i]    = 2;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!done) begin
            chk("pred_taken_if", 32'(pred_taken_if), 32'(mpred(pc_if)));
            chk("pred_target_if", pred_target_if, mtarget(pc_if));
            chk("mispredict", 32'(mispredict), 32'(mmis()));
            chk("redirect_pc", redirect_pc, ex_taken ? ex_target : ex_pc + 32'd4);
            chk("br_cnt", br_cnt, m_br);
            chk("miss_cnt", miss_cnt, m_miss);
        end
    end

    task automatic idle();
        ex_valid       = 0;
        ex_is_branch   = 0;
        ex_taken       = 0;
        ex_pc          = 0;
        ex_target      = 0;
        ex_pred_taken  = 0;
        ex_pred_target = 0;
    endtask

    task automatic set_ex(input logic tk, input logic [31:0] pc, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptgt);
        ex_valid       = 1;
        ex_is_branch   = 1;
        ex_taken       = tk;
        ex_pc          = pc;
        ex_target      = tgt;
        ex_pred_taken  = ptk;
        ex_pred_target = ptgt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] tgt_pool [4];

    initial begin
        rst   = 0;
        pc_if = 32'h100;
        idle();
        #1 rst = 1;
        step();
        step();
        rst = 0;

        // Empty table after reset.
        #2;
        chk("lit_rst_pred", 32'(pred_taken_if), 32'd0);
        chk("lit_rst_tgt", pred_target_if, 32'h104);
        chk("lit_rst_br", br_cnt, 32'd0);
        chk("lit_rst_miss", miss_cnt, 32'd0);

        step();
        set_ex(1, 32'h100, 32'h80, 0, 32'h104);
        #2;
        chk("lit_alloc_mis", 32'(mispredict), 32'd1);
        chk("lit_alloc_redir", redirect_pc, 32'h80);
        step();
        idle();
        #2;
        chk("lit_alloc_misscnt", miss_cnt, 32'd1);
        chk("lit_alloc_brcnt", br_cnt, 32'd1);
        chk("lit_alloc_pred", 32'(pred_taken_if), 32'd1);
        chk("lit_alloc_tgt", pred_target_if, 32'h80);

        // WT -> WNT -> SNT
        step();
        set_ex(0, 32'h100, 32'h80, 1, 32'h80);
        #2;
        chk("lit_nt1_mis", 32'(mispredict), 32'd1);
        chk("lit_nt1_redir", redirect_pc, 32'h104);
        step();
        set_ex(0, 32'h100, 32'h80, 0, 32'h104);
        #2;
        chk("lit_nt2_mis", 32'(mispredict), 32'd0);
        step();
        idle();
        #2;
        chk("lit_snt_pred", 32'(pred_taken_if), 32'd0);
        chk("lit_snt_tgt", pred_target_if, 32'h104);

        // Four takens saturate at ST; one not-taken leaves it predicting taken.
        for (int k = 0; k < 4; k++) begin
            step();
            set_ex(1, 32'h100, 32'h80, 0, 32'h104);
        end
        step();
        set_ex(0, 32'h100, 32'h80, 1, 32'h80);
        step();
        idle();
        #2;
        chk("lit_st_sat_pred", 32'(pred_taken_if), 32'd1);

        // Aliasing: 0x140 shares the index of 0x100 with a different tag.
        step();
        set_ex(1, 32'h140, 32'h200, 0, 32'h144);
        step();
        idle();
        pc_if = 32'h100;
        #2;
        chk("lit_alias_old", 32'(pred_taken_if), 32'd0);
        pc_if = 32'h140;
        #1;
        chk("lit_alias_new", 32'(pred_taken_if), 32'd1);
        chk("lit_alias_tgt", pred_target_if, 32'h200);

        // Target change on a hit.
        step();
        set_ex(1, 32'h140, 32'h90, 1, 32'h80);
        #2;
        chk("lit_tchg_mis", 32'(mispredict), 32'd1);
        chk("lit_tchg_redir", redirect_pc, 32'h90);
        step();
        idle();
        #2;
        chk("lit_tchg_tgt", pred_target_if, 32'h90);

        // Randomized traffic over a small PC pool so entries hit, alias and saturate.
        tgt_pool[0] = 32'h80;
        tgt_pool[1] = 32'h90;
        tgt_pool[2] = 32'h200;
        for (int n = 0; n < 3000; n++) begin
            logic [6:0]  op;
            logic [31:0] epc;
            step();
            tgt_pool[3] = $urandom;
            pc_if = 32'h100 + ($urandom_range(0, 31) << 2) + (($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : 0);
            epc   = 32'h100 + ($urandom_range(0, 31) << 2) + (($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : 0);
            op    = ($urandom_range(0, 3) == 0) ? 7'b0110011 : B_TYPE;
            ex_valid     = ($urandom_range(0, 3) != 0);
            ex_is_branch = (op == B_TYPE);
            ex_pc        = epc;
            ex_taken     = $urandom_range(0, 1);
            ex_target    = tgt_pool[$urandom_range(0, 3)];
            if ($urandom_range(0, 2) != 0) begin
                ex_pred_taken  = mpred(epc);
                ex_pred_target = mtarget(epc);
            end else begin
                ex_pred_taken  = $urandom_range(0, 1);
                ex_pred_target = tgt_pool[$urandom_range(0, 3)];
            end
        end

        // Asynchronous reset mid-cycle clears everything at once.
        step();
        set_ex(1, 32'h140, 32'h90, 1, 32'h90);
        pc_if = 32'h140;
        #1 rst = 1;
        #1;
        chk("lit_mid_rst_br", br_cnt, 32'd0);
        chk("lit_mid_rst_miss", miss_cnt, 32'd0);
        chk("lit_mid_rst_pred", 32'(pred_taken_if), 32'd0);
        ex_valid = 0;
        #1;
        chk("lit_mid_rst_mis", 32'(mispredict), 32'd0);
        step();
        step();
        rst = 0;
        for (int k = 0; k < 3; k++) step();
        #2;
        chk("lit_post_rst_pred", 32'(pred_taken_if), 32'd0);
        chk("lit_post_rst_br", br_cnt, 32'd0);
        chk("lit_post_rst_mis", 32'(mispredict), 32'd0);

        step();
        done = 1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
